// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency word-addressed data memory behind a valid/ready load/store port.
// Optional DMEM_MISALIGN_CHECK_EN: misaligned accesses are suppressed and flagged on resp_err.
module dmem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wd,
    input  logic [3:0]  req_be,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] rd,
    output logic        resp_err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic we_q;
    logic [31:0] addr_q, wd_q, rd_q;
    logic [3:0] be_q;
    logic [31:0] mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic accept, access, ok;
    logic unused_addr;
    assign idx = addr_q[ADDR_WIDTH+1:2];
    assign unused_addr = ^{addr_q[31:ADDR_WIDTH+2], addr_q[1:0]};
    assign accept = state_q == IDLE && req_valid;
    assign access = state_q == WAIT && cnt_q == 4'd0;
`ifdef DMEM_MISALIGN_CHECK_EN
    assign ok = addr_q[1:0] == 2'b00;
    logic err_q;
    always_ff @(posedge clock)
        if (reset) err_q <= 1'b0;
        else if (access) err_q <= !ok;
`else
    assign ok = 1'b1;
`endif
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= 4'd0;
            rd_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            if (access && !we_q && ok) rd_q <= mem[idx];
        end
        if (accept) begin
            we_q <= req_we;
            addr_q <= req_addr;
            wd_q <= req_wd;
            be_q <= req_be;
        end
    end
    // Array is deliberately not reset; reset only blocks an access on its own edge.
    always_ff @(posedge clock)
        if (!reset && access && we_q && ok)
            for (int i = 0; i < 4; i++)
                if (be_q[i]) mem[idx][8*i +: 8] <= wd_q[8*i +: 8];
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: begin
                state_d = req_valid ? WAIT : IDLE;
                cnt_d = req_valid ? 4'(LATENCY - 1) : cnt_q;
            end
            WAIT: begin
                state_d = cnt_q == 4'd0 ? RESP : WAIT;
                cnt_d = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        req_ready = state_q == IDLE;
        resp_valid = state_q == RESP;
        rd = rd_q;
`ifdef DMEM_MISALIGN_CHECK_EN
        resp_err = resp_valid & err_q;
`else
        resp_err = 1'b0;
`endif
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed load/store vectors with a scoreboard-driven response monitor.
module tb_dmem_responder;
    localparam int LAT = 2;
    logic clock = 0, reset = 1, req_valid = 0, req_we = 0;
    logic [31:0] req_addr = 0, req_wd = 0;
    logic [3:0] req_be = 0;
    logic req_ready, resp_valid, resp_err;
    logic [31:0] rd;
    int checks = 0, passes = 0, cyc = 0;
    typedef struct {logic [31:0] rd; logic err; int cyc;} exp_t;
    exp_t sb[$];

    dmem_responder #(.ADDR_WIDTH(8), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wd(req_wd), .req_be(req_be), .req_ready(req_ready),
        .resp_valid(resp_valid), .rd(rd), .resp_err(resp_err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    always @(negedge clock)
        if (resp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected 0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_rd", rd, e.rd);
                chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                chk("resp_latency", cyc, e.cyc);
            end
        end

    task automatic wait_ready();
        int n = 0;
        @(negedge clock);
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) chk("ready_timeout", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input logic [31:0] erd, input logic eerr);
        int low = 0;
        wait_ready();
        req_valid = 1; req_we = we; req_addr = a; req_wd = wd; req_be = be;
        @(posedge clock);
        #1 req_valid = 0;
        sb.push_back('{erd, eerr, cyc + LAT});
        @(negedge clock);
        while (!req_ready && low < 20) begin
            low++;
            @(negedge clock);
        end
        chk("ready_low_cycles", low, 3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        chk("reset_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("reset_rd", rd, 32'h0);
        chk("reset_err", {31'd0, resp_err}, 32'd0);
        issue(1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h00000000, 0);
        issue(0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 0);
        issue(1, 32'h10, 32'h11223344, 4'b0101, 32'hDEADBEEF, 0);
        issue(0, 32'h10, 32'h0, 4'b1111, 32'hDE22BE44, 0);
        issue(1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'hDE22BE44, 0);
        issue(0, 32'h10, 32'h0, 4'b0000, 32'hDE22BE44, 0);
        issue(1, 32'h404, 32'hCAFEF00D, 4'b1111, 32'hDE22BE44, 0);
        issue(0, 32'h004, 32'h0, 4'b0000, 32'hCAFEF00D, 0);
        issue(1, 32'h20, 32'h12345678, 4'b1111, 32'hCAFEF00D, 0);
        issue(0, 32'h20, 32'h0, 4'b0000, 32'h12345678, 0);
        wait_ready();
        req_valid = 1; req_we = 1; req_addr = 32'h20; req_wd = 32'h0BADF00D; req_be = 4'b1111;
        @(posedge clock);
        #1 req_valid = 0; reset = 1;
        @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        chk("midreset_ready", {31'd0, req_ready}, 32'd1);
        chk("midreset_rd", rd, 32'h0);
        repeat (4) @(negedge clock);
        issue(0, 32'h20, 32'h0, 4'b0000, 32'h12345678, 0);
`ifdef DMEM_MISALIGN_CHECK_EN
        issue(0, 32'h13, 32'h0, 4'b0000, 32'h12345678, 1);
`else
        issue(0, 32'h13, 32'h0, 4'b0000, 32'hDE22BE44, 0);
`endif
        repeat (5) @(negedge clock);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the MIPS core: the slave end of the datapath's load/store port. Accepts one word-addressed read or write request via valid/ready, models a fixed access latency with a wait-state counter, and returns read data with a one-cycle response strobe. Sits between the datapath's address, write-data and read-data signals and the control unit, which stalls the PC while `req_ready` is low.

## Interface
- `ADDR_WIDTH`, 8: word-index bits; memory holds 2**ADDR_WIDTH 32-bit words.
- `LATENCY`, 2: cycles from request acceptance to response, legal range 1..15.
- `clock` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address, driven from the datapath's ALU result.
- `req_wd` in 32: store data; byte lane i = bits [8i+7:8i].
- `req_be` in 4: store byte enables, one per lane.
- `req_ready` out 1: responder can accept a request this cycle.
- `resp_valid` out 1: one-cycle response strobe.
- `rd` out 32: load data returned to the datapath's writeback path.
- `resp_err` out 1: error qualifier, valid with `resp_valid`.

## Operation
- States: IDLE, WAIT, RESP. 4-bit counter `cnt`.
- IDLE: `req_ready`=1. When `req_valid`=1 at an edge, the request is accepted:
  - `req_we`, `req_addr`, `req_wd` and `req_be` are captured.
  - `cnt` is loaded with LATENCY-1.
  - The next state is WAIT.
- WAIT: `req_ready`=0.
  - If `cnt`!=0: `cnt` decrements.
  - If `cnt`==0: the memory access is performed at this edge and the next state is RESP.
- RESP: `resp_valid`=1 and `req_ready`=0 for exactly one cycle, then IDLE unconditionally.
- Word index = captured `req_addr[ADDR_WIDTH+1:2]`. Upper address bits are ignored, so addresses alias modulo 2**(ADDR_WIDTH+2).
- Load: `rd` is loaded with the full stored word and `req_be` is ignored. `rd` holds its value until the next load response.
- Store: byte lane i is written only where `req_be[i]`=1. `rd` is unchanged.
  - `req_be`=0000 is a legal no-op store and still produces a response.
- `resp_err` defaults to 0 (see Configuration).
- Inputs are ignored outside IDLE; no queuing.

## Timing
- Reset values: state IDLE, `cnt` 0, `resp_valid` 0, `rd` 0, `resp_err` 0.
- `req_ready` decodes from state, so it reads 1 in the first cycle after the reset edge.
- Requests that coincide with `reset`=1 are dropped.
- Memory array contents are not reset; reads of never-written words are undefined.
- Latency: request accepted at edge N gives `resp_valid`=1 in the cycle following edge N+LATENCY.
- Throughput: one request per LATENCY+1 cycles. A back-to-back request is accepted at edge N+LATENCY+1.
- Store data is visible to a load accepted at or after edge N+LATENCY+1.
- Reset mid-operation (WAIT or RESP) aborts the transaction:
  - A store whose access edge has not yet occurred is discarded.
  - A store already written stays written.
  - No response is issued.
- `reset` has priority over every other transition.

## Configuration
- `DMEM_MISALIGN_CHECK_EN` defined:
  - At the access edge, a captured `req_addr[1:0]`!=00 suppresses the memory access.
  - No store is performed and `rd` is unchanged.
  - `resp_err`=1 during the RESP cycle. Timing is unchanged.
- `DMEM_MISALIGN_CHECK_EN` undefined:
  - `req_addr[1:0]` is ignored and the access is performed at the word index.
  - `resp_err` is tied to 0.

## Test plan
All scenarios use ADDR_WIDTH=8, LATENCY=2.
- Reset then idle: after one reset edge, `req_ready`=1, `resp_valid`=0, `rd`=0x00000000, `resp_err`=0.
- Store then load: store 0xDEADBEEF to 0x10 with `req_be`=1111, then load 0x10 -> `resp_valid` rises 2 cycles after each accept, `rd`=0xDEADBEEF, `req_ready` low for 3 cycles per transaction.
- Byte merge: load 0x10 after storing 0x11223344 with `req_be`=0101 over 0xDEADBEEF -> `rd`=0xDE22BE44. A `req_be`=0000 store then leaves the word unchanged.
- Aliasing: store 0xCAFEF00D to 0x404 (wraps to word 1), then load 0x004 -> `rd`=0xCAFEF00D.
- Reset mid-WAIT: accept a store of 0x0BADF00D to 0x20 (word previously 0x12345678), assert `reset` on the next edge -> no `resp_valid`, and a later load of 0x20 returns 0x12345678.
- Misalign: load 0x13 with the macro defined -> `resp_err`=1 and `rd` unchanged. Without the macro, the same load -> `resp_err`=0 and `rd` = word 4.
